// File: rtl/eth_pkt_fifo_rx.sv
// Store-and-forward RX frame FIFO: frames are written speculatively and committed on a good CRC verdict.
// Define ETH_FIFO_RX_STATS_EN to add saturating commit/drop counters (stat_frames_ok, stat_frames_drop).
//
// state     | meaning
// WR_DATA   | accepting MAC beats into RAM at wr_ptr
// WAIT_CRC  | frame written, waiting for a CRC verdict or timeout
// RD_IDLE   | no committed frame being read
// RD_FETCH  | RAM read of the first word of a frame
// RD_STREAM | word presented on m_axis, advances on handshake
module eth_pkt_fifo_rx #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int DESC_ADDR_WIDTH = 3,
    parameter int CRC_TIMEOUT     = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       crc_valid,
    input  logic                       crc_error,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [DESC_ADDR_WIDTH:0]   frames_pending,
    output logic                       drop_pulse
`ifdef ETH_FIFO_RX_STATS_EN
    ,
    output logic [31:0]                stat_frames_ok,
    output logic [31:0]                stat_frames_drop
`endif
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int QW    = DESC_ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int QD    = 2 ** DESC_ADDR_WIDTH;
    localparam int TW    = $clog2(CRC_TIMEOUT + 1);

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [QW-1:0] QD_P    = QW'(QD);
    localparam logic [TW-1:0] TO_LOAD = TW'(CRC_TIMEOUT - 1);

    typedef enum logic {WR_DATA, WAIT_CRC} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         desc_mem [QD];

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         end_ptr_q, end_ptr_d;
    logic [QW-1:0]         dq_wr_q, dq_wr_d;
    logic [QW-1:0]         dq_rd_q, dq_rd_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  in_frame_q, in_frame_d;
    logic                  ovf_q, ovf_d;
    logic                  dfull_q, dfull_d;
    logic                  tready_q, tready_d;
    logic                  drop_q, drop_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tlast_q, m_tlast_d;

    logic                  full, q_full, q_empty, beat_acc;
    logic                  mem_we, q_push, q_pop, frame_commit, frame_drop;
    logic [QW-1:0]         q_count;

    assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign q_count  = dq_wr_q - dq_rd_q;
    assign q_full   = q_count == QD_P;
    assign q_empty  = q_count == '0;
    assign beat_acc = s_axis_tvalid & tready_q;

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        timer_d      = timer_q;
        in_frame_d   = in_frame_q;
        ovf_d        = ovf_q;
        dfull_d      = dfull_q;
        mem_we       = 1'b0;
        q_push       = 1'b0;
        frame_commit = 1'b0;
        frame_drop   = 1'b0;
        case (wr_state_q)
            WR_DATA: begin
                if (beat_acc) begin
                    // ovf/dfull are re-armed on the first beat of every frame
                    if (in_frame_q) begin
                        ovf_d = ovf_q | full;
                    end else begin
                        ovf_d   = full;
                        dfull_d = q_full;
                    end
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                    in_frame_d = !s_axis_tlast;
                    if (s_axis_tlast) begin
                        wr_state_d = WAIT_CRC;
                        timer_d    = TO_LOAD;
                    end
                end
            end
            WAIT_CRC: begin
                if (crc_valid && !crc_error && !ovf_q && !dfull_q) begin
                    frame_commit = 1'b1;
                    q_push       = 1'b1;
                    commit_ptr_d = wr_ptr_q;
                    wr_state_d   = WR_DATA;
                end else if (crc_valid || crc_error || timer_q == '0) begin
                    frame_drop = 1'b1;
                    wr_ptr_d   = commit_ptr_q;
                    wr_state_d = WR_DATA;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: wr_state_d = WR_DATA;
        endcase
        tready_d = (wr_state_d == WR_DATA);
        drop_d   = frame_drop;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        end_ptr_d  = end_ptr_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        q_pop      = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                // descriptor stays queued until its tlast handshake so the queue depth equals frames_pending
                if (!q_empty) begin
                    end_ptr_d  = desc_mem[dq_rd_q[DESC_ADDR_WIDTH-1:0]];
                    rd_state_d = RD_FETCH;
                end
            end
            RD_FETCH: begin
                m_tdata_d  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
                m_tlast_d  = (rd_ptr_q + PW'(1)) == end_ptr_q;
                rd_state_d = RD_STREAM;
            end
            RD_STREAM: begin
                if (m_axis_tready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (m_tlast_q) begin
                        q_pop      = 1'b1;
                        m_tlast_d  = 1'b0;
                        rd_state_d = RD_IDLE;
                    end else begin
                        m_tdata_d = mem[rd_ptr_d[ADDR_WIDTH-1:0]];
                        m_tlast_d = (rd_ptr_q + PW'(2)) == end_ptr_q;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        dq_wr_d = q_push ? dq_wr_q + QW'(1) : dq_wr_q;
        dq_rd_d = q_pop  ? dq_rd_q + QW'(1) : dq_rd_q;
    end

    always_ff @(posedge aclk) begin
        if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
        if (q_push) desc_mem[dq_wr_q[DESC_ADDR_WIDTH-1:0]] <= wr_ptr_q;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q   <= WR_DATA;
            rd_state_q   <= RD_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            end_ptr_q    <= '0;
            dq_wr_q      <= '0;
            dq_rd_q      <= '0;
            timer_q      <= '0;
            in_frame_q   <= 1'b0;
            ovf_q        <= 1'b0;
            dfull_q      <= 1'b0;
            tready_q     <= 1'b0;
            drop_q       <= 1'b0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            end_ptr_q    <= end_ptr_d;
            dq_wr_q      <= dq_wr_d;
            dq_rd_q      <= dq_rd_d;
            timer_q      <= timer_d;
            in_frame_q   <= in_frame_d;
            ovf_q        <= ovf_d;
            dfull_q      <= dfull_d;
            tready_q     <= tready_d;
            drop_q       <= drop_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign m_axis_tvalid  = (rd_state_q == RD_STREAM);
    assign m_axis_tdata   = m_tdata_q;
    assign m_axis_tlast   = m_tlast_q;
    assign frames_pending = q_count;
    assign drop_pulse     = drop_q;

`ifdef ETH_FIFO_RX_STATS_EN
    logic [31:0] stat_ok_q, stat_ok_d;
    logic [31:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_ok_d   = stat_ok_q;
        stat_drop_d = stat_drop_q;
        if (frame_commit && stat_ok_q != '1) stat_ok_d = stat_ok_q + 32'd1;
        if (frame_drop && stat_drop_q != '1) stat_drop_d = stat_drop_q + 32'd1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_ok_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_ok_q   <= stat_ok_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_frames_ok   = stat_ok_q;
    assign stat_frames_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_eth_pkt_fifo_rx.sv
// Self-checking bench for eth_pkt_fifo_rx: frame-level scoreboard of committed frames vs. m_axis output.
// Build with ETH_FIFO_RX_STATS_EN defined to also check the statistics counters.
module tb_eth_pkt_fifo_rx;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int DAW = 3;
    localparam int TO  = 8;
    localparam int DD  = 2 ** DAW;
    localparam int DEP = 2 ** AW;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          crc_valid = 1'b0;
    logic          crc_error = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [DAW:0]  frames_pending;
    logic          drop_pulse;
`ifdef ETH_FIFO_RX_STATS_EN
    logic [31:0]   stat_frames_ok;
    logic [31:0]   stat_frames_drop;
`endif

    eth_pkt_fifo_rx #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DESC_ADDR_WIDTH(DAW), .CRC_TIMEOUT(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .crc_valid(crc_valid), .crc_error(crc_error),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .frames_pending(frames_pending), .drop_pulse(drop_pulse)
`ifdef ETH_FIFO_RX_STATS_EN
        , .stat_frames_ok(stat_frames_ok), .stat_frames_drop(stat_frames_drop)
`endif
    );

    initial forever #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    int exp_frames = 0;
    int drops_seen = 0;
    int drops_exp = 0;
    int ok_cnt = 0;
    int drop_cnt = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] cur[$];
    logic          stall_v = 1'b0;
    logic [DW-1:0] st_data = '0;
    logic          st_last = 1'b0;

    // Advance one cycle; the output stream is scored on the falling edge.
    task automatic tick();
        logic [DW:0] e;
        @(negedge aclk);
        if (aresetn) begin
            if (stall_v) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== st_data || m_axis_tlast !== st_last) begin
                    failures++;
                    $display("FAIL stall_hold got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, st_data, st_last);
                end
            end
            if (drop_pulse === 1'b1) drops_seen++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got d=%h l=%0b want no beat", m_axis_tdata, m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== e) begin
                        failures++;
                        $display("FAIL beat got d=%h l=%0b want d=%h l=%0b",
                                 m_axis_tdata, m_axis_tlast, e[DW-1:0], e[DW]);
                    end
                    if (e[DW]) exp_frames--;
                end
            end
            stall_v = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            st_data = m_axis_tdata;
            st_last = m_axis_tlast;
        end else begin
            stall_v = 1'b0;
        end
        @(posedge aclk);
        #1;
        if (rdy_mode == 2) m_axis_tready = 1'($urandom_range(0, 1));
        else m_axis_tready = (rdy_mode == 1);
    endtask

    task automatic send_frame(input int len, input bit fixed, input logic [DW-1:0] base);
        int n = 0;
        logic [DW-1:0] d;
        cur.delete();
        while (s_axis_tready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL tready_wait got tready=%0b want 1 within 200 cycles", s_axis_tready);
        end
        for (int i = 0; i < len; i++) begin
            d = fixed ? base + DW'(i) : DW'($urandom);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tlast  = (i == len - 1);
            cur.push_back({s_axis_tlast, d});
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // kind: 0 = crc_valid, 1 = crc_error, 2 = both strobes
    task automatic verdict(input int kind, input int dly, input bit exp_ok);
        repeat (dly - 1) tick();
        crc_valid = (kind == 0 || kind == 2);
        crc_error = (kind == 1 || kind == 2);
        tick();
        crc_valid = 1'b0;
        crc_error = 1'b0;
        if (exp_ok) begin
            foreach (cur[i]) exp_q.push_back(cur[i]);
            exp_frames++;
            ok_cnt++;
        end else begin
            drops_exp++;
            drop_cnt++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d words outstanding want 0", exp_q.size());
        end
        checks++;
        if (frames_pending !== '0 || m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL drain_idle got pending=%0d tvalid=%0b want 0 0", frames_pending, m_axis_tvalid);
        end
        checks++;
        if (drops_seen != drops_exp) begin
            failures++;
            $display("FAIL drop_count got %0d want %0d", drops_seen, drops_exp);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tdata !== '0 || frames_pending !== '0 || drop_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%0b v=%0b l=%0b d=%h pend=%0d drop=%0b want all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, frames_pending, drop_pulse);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        rdy_mode = 1;
        send_frame(4, 1'b1, 32'hA0);
        verdict(0, 2, 1'b1);
        checks++;
        if (frames_pending !== 4'd1 || m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL basic_commit got pending=%0d tvalid=%0b want 1 0", frames_pending, m_axis_tvalid);
        end
        drain();
    endtask

    task automatic test_crc_error();
        rdy_mode = 1;
        send_frame(6, 1'b0, '0);
        verdict(1, 3, 1'b0);
        tick();
        checks++;
        if (drops_seen != drops_exp || frames_pending !== '0) begin
            failures++;
            $display("FAIL crc_error_drop got drops=%0d pend=%0d want %0d 0", drops_seen, frames_pending, drops_exp);
        end
        send_frame(5, 1'b0, '0);
        verdict(0, 1, 1'b1);
        drain();
    endtask

    task automatic test_timeout();
        rdy_mode = 1;
        send_frame(4, 1'b0, '0);
        for (int i = 0; i <= TO + 1; i++) begin
            checks++;
            if (drop_pulse !== (i == TO)) begin
                failures++;
                $display("FAIL timeout_pulse cycle %0d got %0b want %0b", i, drop_pulse, (i == TO));
            end
            tick();
        end
        drops_exp++;
        drop_cnt++;
        crc_valid = 1'b1;
        tick();
        crc_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (frames_pending !== '0 || drops_seen != drops_exp) begin
            failures++;
            $display("FAIL late_crc got pend=%0d drops=%0d want 0 %0d", frames_pending, drops_seen, drops_exp);
        end
        drain();
    endtask

    task automatic test_overflow_wrap();
        rdy_mode = 1;
        send_frame(DEP + 1, 1'b0, '0);
        verdict(0, 2, 1'b0);
        tick();
        checks++;
        if (drops_seen != drops_exp || frames_pending !== '0) begin
            failures++;
            $display("FAIL ovf_drop got drops=%0d pend=%0d want %0d 0", drops_seen, frames_pending, drops_exp);
        end
        for (int f = 0; f < 5; f++) begin
            send_frame(300, 1'b1, DW'(f * 32'h1000));
            verdict(0, 2, 1'b1);
        end
        drain();
    endtask

    task automatic test_dfull();
        rdy_mode = 0;
        for (int f = 0; f < DD; f++) begin
            send_frame(3, 1'b0, '0);
            verdict(0, 2, 1'b1);
        end
        tick();
        checks++;
        if (frames_pending !== 4'(DD)) begin
            failures++;
            $display("FAIL dfull_pending got %0d want %0d", frames_pending, DD);
        end
        send_frame(3, 1'b0, '0);
        verdict(0, 2, 1'b0);
        tick();
        checks++;
        if (drops_seen != drops_exp || frames_pending !== 4'(DD)) begin
            failures++;
            $display("FAIL dfull_drop got drops=%0d pend=%0d want %0d %0d", drops_seen, frames_pending, drops_exp, DD);
        end
        rdy_mode = 1;
        drain();
    endtask

    task automatic test_random();
        int kind, r, n;
        rdy_mode = 2;
        for (int f = 0; f < 20; f++) begin
            n = 0;
            while (exp_frames >= DD && n < 2000) begin
                tick();
                n++;
            end
            send_frame($urandom_range(1, 16), 1'b0, '0);
            r = $urandom_range(0, 99);
            kind = (r < 70) ? 0 : (r < 85) ? 1 : 2;
            verdict(kind, $urandom_range(1, TO), kind == 0);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        rdy_mode = 1;
    endtask

    task automatic test_stats();
`ifdef ETH_FIFO_RX_STATS_EN
        checks++;
        if (stat_frames_ok !== 32'(ok_cnt) || stat_frames_drop !== 32'(drop_cnt)) begin
            failures++;
            $display("FAIL stats got ok=%0d drop=%0d want %0d %0d", stat_frames_ok, stat_frames_drop, ok_cnt, drop_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        rdy_mode = 0;
        send_frame(4, 1'b0, '0);
        verdict(0, 2, 1'b1);
        send_frame(4, 1'b0, '0);
        verdict(0, 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'($urandom);
            tick();
        end
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        exp_frames = 0;
        ok_cnt = 0;
        drop_cnt = 0;
        aresetn = 1'b1;
        tick();
        checks++;
        if (frames_pending !== '0 || m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got pend=%0d tvalid=%0b want 0 0", frames_pending, m_axis_tvalid);
        end
        rdy_mode = 1;
        send_frame(3, 1'b1, 32'hC0);
        verdict(0, 2, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_error();
        test_timeout();
        test_overflow_wrap();
        test_dfull();
        test_random();
        test_stats();
        test_reset_mid();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
